// File: rtl/tile_dispatcher.sv
// Round-robin job dispatcher for a pool of MLP tiles; results return strictly in job-arrival order.
// Steers external image/result muxes by tile index only; no image or result data passes through.
module tile_dispatcher #(
  parameter  int NUM_TILES = 4,
  parameter  int TAG_W     = 8,
  localparam int IDX_W     = $clog2(NUM_TILES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  input  logic [TAG_W-1:0]     job_tag,
  output logic                 job_ready,
  output logic [IDX_W-1:0]     img_sel,
  output logic [NUM_TILES-1:0] tile_start,
  input  logic [NUM_TILES-1:0] tile_done,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [TAG_W-1:0]     res_tag,
  output logic [IDX_W-1:0]     res_sel,
  output logic [IDX_W:0]       busy_cnt,
  output logic                 err
);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } tile_st_e;

  tile_st_e         st_q  [NUM_TILES];
  tile_st_e         st_d  [NUM_TILES];
  logic [TAG_W-1:0] tag_q [NUM_TILES];
  logic [TAG_W-1:0] tag_d [NUM_TILES];
  logic [IDX_W-1:0] ord_q [NUM_TILES];
  logic [IDX_W-1:0] ord_d [NUM_TILES];

  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [IDX_W:0]   busy_cnt_q, busy_cnt_d;
  logic             err_q, err_d;

  logic             any_free;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] head;
  logic             dispatch;
  logic             drain;

  // First FREE tile at or after rr; scanning downward lets the nearest candidate win.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand     = '0;
    pick     = rr_q;
    any_free = 1'b0;
    for (int k = NUM_TILES - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_q) + k) % NUM_TILES);
      if (st_q[cand] == FREE) begin
        pick     = cand;
        any_free = 1'b1;
      end
    end
  end

  assign head      = ord_q[rd_ptr_q];
  assign res_valid = (cnt_q != '0) && (st_q[head] == HOLD);
  assign res_sel   = head;
  assign res_tag   = tag_q[head];
  assign job_ready = any_free;
  assign img_sel   = pick;
  assign dispatch  = job_valid && any_free;
  assign drain     = res_valid && res_ready;
  assign busy_cnt  = busy_cnt_q;
  assign err       = err_q;

  always_comb begin
    tile_start = '0;
    if (dispatch) tile_start[pick] = 1'b1;
  end

  // Done, drain and dispatch touch tiles in BUSY, HOLD and FREE respectively, so they never collide.
  always_comb begin
    st_d       = st_q;
    tag_d      = tag_q;
    ord_d      = ord_q;
    rr_d       = rr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    busy_cnt_d = '0;

    for (int i = 0; i < NUM_TILES; i++) begin
      if (tile_done[i]) begin
        if (st_q[i] == BUSY) st_d[i] = HOLD;
        else                 err_d   = 1'b1;
      end
    end

    if (drain) begin
      st_d[head] = FREE;
      rd_ptr_d   = (rd_ptr_q == IDX_W'(NUM_TILES - 1)) ? '0 : rd_ptr_q + IDX_W'(1);
    end

    if (dispatch) begin
      st_d[pick]      = BUSY;
      tag_d[pick]     = job_tag;
      ord_d[wr_ptr_q] = pick;
      wr_ptr_d        = (wr_ptr_q == IDX_W'(NUM_TILES - 1)) ? '0 : wr_ptr_q + IDX_W'(1);
      rr_d            = (pick == IDX_W'(NUM_TILES - 1)) ? '0 : pick + IDX_W'(1);
    end

    case ({dispatch, drain})
      2'b10:   cnt_d = cnt_q + (IDX_W + 1)'(1);
      2'b01:   cnt_d = cnt_q - (IDX_W + 1)'(1);
      default: cnt_d = cnt_q;
    endcase

    for (int i = 0; i < NUM_TILES; i++) begin
      if (st_d[i] != FREE) busy_cnt_d = busy_cnt_d + (IDX_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TILES; i++) begin
        st_q[i]  <= FREE;
        tag_q[i] <= '0;
        ord_q[i] <= '0;
      end
      rr_q       <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      busy_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      tag_q      <= tag_d;
      ord_q      <= ord_d;
      rr_q       <= rr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      busy_cnt_q <= busy_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_tile_dispatcher.sv
// Bench for tile_dispatcher: directed scenarios plus a randomized run checked against a
// queue-based model of tile occupancy and in-order result return.
module tb_tile_dispatcher;
  localparam int N  = 4;
  localparam int TW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid = 1'b0;
  logic [TW-1:0] job_tag = '0;
  logic          job_ready;
  logic [IW-1:0] img_sel;
  logic [N-1:0]  tile_start;
  logic [N-1:0]  tile_done = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [TW-1:0] res_tag;
  logic [IW-1:0] res_sel;
  logic [IW:0]   busy_cnt;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tile_dispatcher #(.NUM_TILES(N), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_tag(job_tag), .job_ready(job_ready), .img_sel(img_sel),
    .tile_start(tile_start), .tile_done(tile_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_sel(res_sel),
    .busy_cnt(busy_cnt), .err(err)
  );

  // Reference model: tile occupancy (0 free, 1 running, 2 finished), tags, arrival queue.
  int m_st  [N];
  int m_tag [N];
  int m_q [$];
  int m_rr;
  bit m_err;

  function automatic int m_pick();
    for (int k = 0; k < N; k++) if (m_st[(m_rr + k) % N] == 0) return (m_rr + k) % N;
    return -1;
  endfunction

  function automatic bit m_rv();
    return (m_q.size() > 0) && (m_st[m_q[0]] == 2);
  endfunction

  function automatic int m_busy();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_st[i] != 0) c++;
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin m_st[i] = 0; m_tag[i] = 0; end
    m_q.delete();
    m_rr  = 0;
    m_err = 1'b0;
  endtask

  // One clock edge: model follows the sampled inputs, then job/done inputs return to idle.
  task automatic tick();
    int p, hd;
    bit disp, drn;
    @(posedge clk);
    p    = m_pick();
    disp = job_valid && (p >= 0);
    drn  = m_rv() && res_ready;
    hd   = drn ? m_q[0] : -1;
    for (int i = 0; i < N; i++) begin
      if (tile_done[i]) begin
        if (m_st[i] == 1) m_st[i] = 2;
        else              m_err   = 1'b1;
      end
    end
    if (drn) begin
      m_st[hd] = 0;
      void'(m_q.pop_front());
    end
    if (disp) begin
      m_st[p]  = 1;
      m_tag[p] = int'(job_tag);
      m_q.push_back(p);
      m_rr = (p + 1) % N;
    end
    #1;
    job_valid = 1'b0;
    tile_done = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; job_valid = 1'b0; tile_done = '0; res_ready = 1'b0; job_tag = '0;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; job_valid = 1'b0; tile_done = '0;
    #1;
    n_tests++; if (job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready: got %b want 1", job_ready); end
    n_tests++; if (img_sel !== 2'd0) begin n_fail++; $display("FAIL reset_img_sel: got %0d want 0", img_sel); end
    n_tests++; if (tile_start !== 4'b0000) begin n_fail++; $display("FAIL reset_tile_start: got %b want 0000", tile_start); end
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_tests++; if (busy_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_busy_cnt: got %0d want 0", busy_cnt); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    do_reset();
  endtask

  task automatic test_single_job();
    do_reset();
    job_valid = 1'b1; job_tag = 8'h11;
    @(negedge clk);
    n_tests++; if (tile_start !== 4'b0001) begin n_fail++; $display("FAIL single_start: got %b want 0001", tile_start); end
    tick();
    repeat (4) tick();
    @(negedge clk);
    n_tests++; if (busy_cnt !== 3'd1) begin n_fail++; $display("FAIL single_busy_cnt: got %0d want 1", busy_cnt); end
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", res_valid); end
    tile_done = 4'b0001;
    tick();
    @(negedge clk);
    n_tests++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL single_res_valid: got %b want 1", res_valid); end
    n_tests++; if (res_tag !== 8'h11) begin n_fail++; $display("FAIL single_res_tag: got %h want 11", res_tag); end
    n_tests++; if (res_sel !== 2'd0) begin n_fail++; $display("FAIL single_res_sel: got %0d want 0", res_sel); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (busy_cnt !== 3'd0) begin n_fail++; $display("FAIL single_freed: got busy_cnt %0d want 0", busy_cnt); end
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_drain_valid: got %b want 0", res_valid); end
    n_tests++; if (img_sel !== 2'd1) begin n_fail++; $display("FAIL single_rr_advance: got img_sel %0d want 1", img_sel); end
    tick();
  endtask

  task automatic fill_pool(input logic [TW-1:0] base, input bit check);
    for (int i = 0; i < N; i++) begin
      job_valid = 1'b1; job_tag = base + TW'(i);
      @(negedge clk);
      if (check) begin
        n_tests++;
        if (tile_start !== (N'(1) << i)) begin n_fail++; $display("FAIL fill_start%0d: got %b want %b", i, tile_start, N'(1) << i); end
      end
      tick();
    end
  endtask

  task automatic test_fill_pool();
    do_reset();
    fill_pool(8'd1, 1'b1);
    job_valid = 1'b1; job_tag = 8'd5;
    @(negedge clk);
    n_tests++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL fill_job_ready: got %b want 0", job_ready); end
    n_tests++; if (tile_start !== 4'b0000) begin n_fail++; $display("FAIL fill_no_start: got %b want 0000", tile_start); end
    n_tests++; if (busy_cnt !== 3'd4) begin n_fail++; $display("FAIL fill_busy_cnt: got %0d want 4", busy_cnt); end
    tick();
  endtask

  // Continues from the full pool left by test_fill_pool (tags 1..4 on tiles 0..3).
  task automatic test_out_of_order();
    logic [N-1:0] dn  [8] = '{4'b0100, 4'b0001, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    bit           rv  [8] = '{0, 0, 1, 0, 1, 1, 1, 0};
    int           tg  [8] = '{0, 0, 1, 0, 2, 3, 4, 0};
    res_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tile_done = dn[c];
      @(negedge clk);
      n_tests++;
      if (res_valid !== rv[c]) begin n_fail++; $display("FAIL ooo_valid_c%0d: got %b want %b", c, res_valid, rv[c]); end
      if (rv[c]) begin
        n_tests++;
        if (res_tag !== TW'(tg[c])) begin n_fail++; $display("FAIL ooo_tag_c%0d: got %0d want %0d", c, res_tag, tg[c]); end
        n_tests++;
        if (res_sel !== IW'(tg[c] - 1)) begin n_fail++; $display("FAIL ooo_sel_c%0d: got %0d want %0d", c, res_sel, tg[c] - 1); end
      end
      tick();
    end
    res_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (busy_cnt !== 3'd0) begin n_fail++; $display("FAIL ooo_busy_cnt: got %0d want 0", busy_cnt); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ooo_err: got %b want 0", err); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    fill_pool(8'hA0, 1'b0);
    tile_done = 4'b1111;
    tick();
    res_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if (res_valid !== 1'b1 || res_tag !== 8'hA0 || res_sel !== 2'd0)
        begin n_fail++; $display("FAIL bp_stall_c%0d: got v=%b tag=%h sel=%0d want v=1 tag=a0 sel=0", c, res_valid, res_tag, res_sel); end
      n_tests++;
      if (busy_cnt !== 3'd4 || job_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_nofree_c%0d: got busy=%0d ready=%b want busy=4 ready=0", c, busy_cnt, job_ready); end
      tick();
    end
    res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (res_valid !== 1'b1 || res_tag !== 8'hA0 + TW'(c) || res_sel !== IW'(c))
        begin n_fail++; $display("FAIL bp_drain_c%0d: got v=%b tag=%h sel=%0d want v=1 tag=%h sel=%0d", c, res_valid, res_tag, res_sel, 8'hA0 + TW'(c), c); end
      tick();
    end
    res_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (res_valid !== 1'b0 || busy_cnt !== 3'd0)
      begin n_fail++; $display("FAIL bp_empty: got v=%b busy=%0d want v=0 busy=0", res_valid, busy_cnt); end
    tick();
  endtask

  task automatic test_rr_wrap();
    do_reset();
    fill_pool(8'h30, 1'b0);
    tile_done = 4'b0001;
    tick();
    res_ready = 1'b1; job_valid = 1'b1; job_tag = 8'h40;
    @(negedge clk);
    n_tests++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL rr_same_cycle_ready: got %b want 0", job_ready); end
    n_tests++; if (res_valid !== 1'b1 || res_sel !== 2'd0)
      begin n_fail++; $display("FAIL rr_head: got v=%b sel=%0d want v=1 sel=0", res_valid, res_sel); end
    tick();
    res_ready = 1'b0; job_valid = 1'b1; job_tag = 8'h40;
    @(negedge clk);
    n_tests++; if (job_ready !== 1'b1 || img_sel !== 2'd0 || tile_start !== 4'b0001)
      begin n_fail++; $display("FAIL rr_freed_tile: got ready=%b sel=%0d start=%b want 1/0/0001", job_ready, img_sel, tile_start); end
    tick();
    tile_done = 4'b0110;
    tick();
    res_ready = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_tests++;
      if (res_valid !== 1'b1 || res_tag !== 8'h30 + TW'(c) || res_sel !== IW'(c))
        begin n_fail++; $display("FAIL rr_drain%0d: got v=%b tag=%h sel=%0d", c, res_valid, res_tag, res_sel); end
      tick();
    end
    res_ready = 1'b0; job_valid = 1'b1; job_tag = 8'h41;
    @(negedge clk);
    n_tests++; if (img_sel !== 2'd1 || tile_start !== 4'b0010)
      begin n_fail++; $display("FAIL rr_from1: got sel=%0d start=%b want 1/0010", img_sel, tile_start); end
    tick();
    job_valid = 1'b1; job_tag = 8'h42;
    @(negedge clk);
    n_tests++; if (img_sel !== 2'd2 || tile_start !== 4'b0100)
      begin n_fail++; $display("FAIL rr_next2: got sel=%0d start=%b want 2/0100", img_sel, tile_start); end
    tick();
  endtask

  task automatic test_error_reset();
    do_reset();
    job_valid = 1'b1; job_tag = 8'h55;
    tick();
    tile_done = 4'b1000;
    @(negedge clk);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b want 0", err); end
    tick();
    @(negedge clk);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
    repeat (3) tick();
    job_valid = 1'b1; job_tag = 8'h66; tile_done = 4'b0001;
    tick();
    @(negedge clk);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
    n_tests++; if (res_valid !== 1'b1 || res_tag !== 8'h55 || busy_cnt !== 3'd2)
      begin n_fail++; $display("FAIL err_inflight: got v=%b tag=%h busy=%0d want 1/55/2", res_valid, res_tag, busy_cnt); end
    rst = 1'b1;
    #1;
    n_tests++; if (res_valid !== 1'b0 || busy_cnt !== 3'd0 || err !== 1'b0)
      begin n_fail++; $display("FAIL async_rst_a: got v=%b busy=%0d err=%b want 0/0/0", res_valid, busy_cnt, err); end
    n_tests++; if (job_ready !== 1'b1 || img_sel !== 2'd0 || tile_start !== 4'b0000)
      begin n_fail++; $display("FAIL async_rst_b: got ready=%b sel=%0d start=%b want 1/0/0000", job_ready, img_sel, tile_start); end
    do_reset();
  endtask

  task automatic test_random();
    int p, hd;
    logic [N-1:0] exp_start;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      job_valid = ($urandom_range(0, 99) < 55);
      job_tag   = TW'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) tile_done[i] = (m_st[i] == 1) && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      p = m_pick();
      exp_start = (job_valid && p >= 0) ? (N'(1) << p) : '0;
      n_tests++; if (job_ready !== (p >= 0)) begin n_fail++; $display("FAIL rnd_ready_c%0d: got %b want %b", c, job_ready, p >= 0); end
      if (p >= 0) begin
        n_tests++; if (img_sel !== IW'(p)) begin n_fail++; $display("FAIL rnd_img_sel_c%0d: got %0d want %0d", c, img_sel, p); end
      end
      n_tests++; if (tile_start !== exp_start) begin n_fail++; $display("FAIL rnd_start_c%0d: got %b want %b", c, tile_start, exp_start); end
      n_tests++; if (res_valid !== m_rv()) begin n_fail++; $display("FAIL rnd_valid_c%0d: got %b want %b", c, res_valid, m_rv()); end
      if (m_rv()) begin
        hd = m_q[0];
        n_tests++; if (res_sel !== IW'(hd) || res_tag !== TW'(m_tag[hd]))
          begin n_fail++; $display("FAIL rnd_result_c%0d: got sel=%0d tag=%h want sel=%0d tag=%h", c, res_sel, res_tag, hd, m_tag[hd]); end
      end
      n_tests++; if (busy_cnt !== (IW + 1)'(m_busy())) begin n_fail++; $display("FAIL rnd_busy_c%0d: got %0d want %0d", c, busy_cnt, m_busy()); end
      n_tests++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err_c%0d: got %b want %b", c, err, m_err); end
      tick();
    end
    res_ready = 1'b0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single_job();
    test_fill_pool();
    test_out_of_order();
    test_backpressure();
    test_rr_wrap();
    test_error_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
